// File: rtl/dual_priority_encoder_pipe.sv
// Two-stage pipelined priority encoder: reports the winning and runner-up set
// bits of a request vector behind a valid/ready handshake with backpressure.
module dual_priority_encoder_pipe #(
  parameter int WIDTH     = 12,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             first_vld,
  output logic [IDX_W-1:0] first_idx,
  output logic             second_vld,
  output logic [IDX_W-1:0] second_idx
);

  localparam logic [IDX_W-1:0] IDX_NONE = '1;
  localparam logic [WIDTH-1:0] ONE_HOT0 = WIDTH'(1);

  // Returns {vld, idx}; later matches in the scan overwrite earlier ones,
  // so the scan order decides which end of the vector wins.
  function automatic logic [IDX_W:0] encode(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    logic             vld;
    idx = IDX_NONE;
    vld = 1'b0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) begin
          idx = IDX_W'(i);
          vld = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (v[i]) begin
          idx = IDX_W'(i);
          vld = 1'b1;
        end
      end
    end
    return {vld, idx};
  endfunction

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_first_vld;
  logic [IDX_W-1:0] s1_first_idx;
  logic             s2_valid;

  logic             s1_load;
  logic             s2_load;
  logic             enc_in_vld;
  logic [IDX_W-1:0] enc_in_idx;
  logic             enc_rem_vld;
  logic [IDX_W-1:0] enc_rem_idx;
  logic [WIDTH-1:0] s1_mask;
  logic [WIDTH-1:0] s1_remainder;

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_valid;

  assign {enc_in_vld, enc_in_idx} = encode(in_data);

  assign s1_mask      = s1_first_vld ? (ONE_HOT0 << s1_first_idx) : '0;
  assign s1_remainder = s1_data & ~s1_mask;
  assign {enc_rem_vld, enc_rem_idx} = encode(s1_remainder);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      s1_first_vld <= 1'b0;
      s1_first_idx <= IDX_NONE;
    end else begin
      if (s1_load) begin
        s1_valid     <= 1'b1;
        s1_data      <= in_data;
        s1_first_vld <= enc_in_vld;
        s1_first_idx <= enc_in_idx;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Result fields only move on s2_load, so they hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      first_vld  <= 1'b0;
      first_idx  <= IDX_NONE;
      second_vld <= 1'b0;
      second_idx <= IDX_NONE;
    end else begin
      if (s2_load) begin
        s2_valid   <= 1'b1;
        first_vld  <= s1_first_vld;
        first_idx  <= s1_first_idx;
        second_vld <= enc_rem_vld;
        second_idx <= enc_rem_idx;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_priority_encoder_pipe.sv
// Directed bench for dual_priority_encoder_pipe: an MSB-first and an LSB-first
// instance share stimulus; results are compared against hand-computed tables.
module tb_dual_priority_encoder_pipe;

  localparam int W  = 12;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  in_data;

  logic          rdy_m, ov_m, fv_m, sv_m;
  logic [IW-1:0] fi_m, si_m;
  logic          rdy_l, ov_l, fv_l, sv_l;
  logic [IW-1:0] fi_l, si_l;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dual_priority_encoder_pipe #(.WIDTH(W), .IDX_W(IW), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m),
    .in_data(in_data), .out_valid(ov_m), .out_ready(out_ready),
    .first_vld(fv_m), .first_idx(fi_m), .second_vld(sv_m), .second_idx(si_m)
  );

  dual_priority_encoder_pipe #(.WIDTH(W), .IDX_W(IW), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_l),
    .in_data(in_data), .out_valid(ov_l), .out_ready(out_ready),
    .first_vld(fv_l), .first_idx(fi_l), .second_vld(sv_l), .second_idx(si_l)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [9:0]   em;
    logic [9:0]   el;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [9:0] mk(input logic fv, input int fi, input logic sv, input int si);
    return {fv, 4'(fi), sv, 4'(si)};
  endfunction

  function automatic logic [9:0] res_m();
    return {fv_m, fi_m, sv_m, si_m};
  endfunction

  function automatic logic [9:0] res_l();
    return {fv_l, fi_l, sv_l, si_l};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [W-1:0] bp[3];
    logic [9:0]   drain_exp[3];
    int n, got, first, k, stale;

    tbl[0]  = '{12'h000, mk(0, 15, 0, 15), mk(0, 15, 0, 15)};
    tbl[1]  = '{12'h801, mk(1, 11, 1, 0),  mk(1, 0, 1, 11)};
    tbl[2]  = '{12'h030, mk(1, 5, 1, 4),   mk(1, 4, 1, 5)};
    tbl[3]  = '{12'h400, mk(1, 10, 0, 15), mk(1, 10, 0, 15)};
    tbl[4]  = '{12'h0A0, mk(1, 7, 1, 5),   mk(1, 5, 1, 7)};
    tbl[5]  = '{12'hFFF, mk(1, 11, 1, 10), mk(1, 0, 1, 1)};
    tbl[6]  = '{12'h001, mk(1, 0, 0, 15),  mk(1, 0, 0, 15)};
    tbl[7]  = '{12'h800, mk(1, 11, 0, 15), mk(1, 11, 0, 15)};
    tbl[8]  = '{12'h003, mk(1, 1, 1, 0),   mk(1, 0, 1, 1)};
    tbl[9]  = '{12'h00C, mk(1, 3, 1, 2),   mk(1, 2, 1, 3)};
    tbl[10] = '{12'h924, mk(1, 11, 1, 8),  mk(1, 2, 1, 5)};
    tbl[11] = '{12'h100, mk(1, 8, 0, 15),  mk(1, 8, 0, 15)};

    bp[0] = 12'h003; bp[1] = 12'h00C; bp[2] = 12'h030;
    drain_exp[0] = mk(1, 1, 1, 0);
    drain_exp[1] = mk(1, 3, 1, 2);
    drain_exp[2] = mk(1, 5, 1, 4);

    // Reset state
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {ov_m, ov_l}, 2'b00);
    check("rst_fields_m", res_m(), mk(0, 15, 0, 15));
    check("rst_fields_l", res_l(), mk(0, 15, 0, 15));
    reset = 1'b0;
    #1;
    check("rst_in_ready", {rdy_m, rdy_l}, 2'b11);

    // One vector at a time through an idle pipe
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = tbl[i].d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      @(negedge clk);
      n = 0;
      while (!ov_m && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!ov_m) begin
        tests++; fails++;
        $display("FAIL tbl_timeout[%0d]: out_valid never rose within 10 cycles", i);
      end else begin
        check($sformatf("tbl_latency[%0d]", i), n, 1);
        check($sformatf("tbl_msb[%0d]", i), res_m(), tbl[i].em);
        check($sformatf("tbl_lsb[%0d]", i), res_l(), tbl[i].el);
      end
    end

    // Streaming: 8 back-to-back vectors
    @(posedge clk);
    got = 0; first = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      in_valid = (c < 8);
      in_data  = (c < 8) ? tbl[c].d : W'($urandom);
      @(negedge clk);
      if (c < 8) check($sformatf("stream_in_ready[%0d]", c), rdy_m, 1'b1);
      if (ov_m) begin
        if (first < 0) first = c;
        if (got < 8) begin
          check($sformatf("stream_msb[%0d]", got), res_m(), tbl[got].em);
          check($sformatf("stream_lsb[%0d]", got), res_l(), tbl[got].el);
        end
        got++;
      end
      @(posedge clk);
    end
    check("stream_first_cycle", first, 2);
    check("stream_count", got, 8);

    // Backpressure: offer three vectors while the output is stalled
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      in_valid = (k < 3);
      if (k < 3) in_data = bp[k];
      @(negedge clk);
      if (in_valid && rdy_m) k++;
      @(posedge clk);
    end
    check("bp_accepted", k, 2);
    @(negedge clk);
    check("bp_in_ready", rdy_m, 1'b0);
    check("bp_hold", {ov_m, res_m()}, {1'b1, mk(1, 1, 1, 0)});
    repeat (3) @(negedge clk);
    check("bp_hold_later", {ov_m, res_m()}, {1'b1, mk(1, 1, 1, 0)});

    out_ready = 1'b1;
    #1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      if (ov_m) begin
        if (got < 3) check($sformatf("bp_drain[%0d]", got), res_m(), drain_exp[got]);
        got++;
      end
      if (in_valid && rdy_m) k++;
      @(posedge clk); #1;
      in_valid = (k < 3);
      if (k < 3) in_data = bp[k];
      @(negedge clk);
    end
    check("bp_all_accepted", k, 3);
    check("bp_drain_count", got, 3);

    // Reset with both stages full
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 12'h801;
    @(posedge clk); #1;
    in_data = 12'h030;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rmid_pre_full", {ov_m, rdy_m}, 2'b10);
    #2 reset = 1'b1;
    #1;
    check("rmid_out_valid", {ov_m, ov_l}, 2'b00);
    check("rmid_fields_m", res_m(), mk(0, 15, 0, 15));
    check("rmid_fields_l", res_l(), mk(0, 15, 0, 15));
    @(posedge clk); #2;
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rmid_in_ready", {rdy_m, rdy_l}, 2'b11);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov_m || ov_l) stale++;
    end
    check("rmid_no_stale", stale, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dual_priority_encoder_pipe.md
Name: dual_priority_encoder_pipe

Overview:
- Parametrised, pipelined dual priority encoder. Reports the highest-priority and second-highest-priority set bits of a WIDTH-bit request vector.
- Priority direction is selectable at elaboration time.
- Sits between request-collection logic and downstream arbiters/schedulers.
- Valid/ready handshake on both sides; full backpressure support.

Parameters:
- WIDTH, 12, request vector width (2 to 64).
- IDX_W, $clog2(WIDTH), index output width.
- MSB_FIRST, 1, 1 = highest bit number wins; 0 = lowest bit number wins.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  request vector.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream accepts the result.
- first_vld  output  1  at least one bit was set.
- first_idx  output  IDX_W  index of the winning bit; all ones when first_vld=0.
- second_vld  output  1  at least two bits were set.
- second_idx  output  IDX_W  index of the runner-up bit; all ones when second_vld=0.

Behaviour:
- Reset (async assert, released synchronously by the clock domain):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - first_vld=0, second_vld=0.
  - first_idx and second_idx all ones.
  - in_ready=1 once reset is deasserted.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1 (S1):
  - On input transfer, registers in_data into s1_data.
  - Computes the first index combinationally from in_data and registers s1_first_idx / s1_first_vld.
- Stage 2 (S2):
  - Masks the s1_first bit out of s1_data.
  - Encodes the remainder with the same priority rule.
  - Registers all four result fields; out_valid = s2_valid.
- Latency: 2 cycles from input transfer to out_valid, with no stalls. Throughput is 1 vector/cycle.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !s1_valid || s2_load. This is a combinational path from out_ready to in_ready and is permitted.
- s1_valid:
  - Set on s1_load.
  - Cleared on s2_load without s1_load.
  - Unchanged otherwise.
- s2_valid:
  - Set on s2_load.
  - Cleared on output transfer without s2_load.
- Holding: while out_valid && !out_ready, all output fields hold stable. Results are never dropped or duplicated.
- Simultaneous load of both stages in one cycle is legal; this is full streaming.
- Encoding rules:
  - in_data=0: first_vld=0, second_vld=0, both idx all ones.
  - Exactly one bit set: second_vld=0, second_idx all ones.
- When WIDTH is a power of two, an all-ones idx is also a legal index. Consumers must qualify with the vld flags.
- MSB_FIRST=1 matches the existing 12-bit encoder's winner (bit 11 highest). MSB_FIRST=0 mirrors it.
- in_data bits are don't-care when in_valid=0. No state changes without a transfer.
- Reset mid-operation flushes both stages immediately. In-flight vectors are discarded and no out_valid pulse follows.

Test Plan (WIDTH=12, MSB_FIRST=1 unless noted):
- Zero vector: send in_data=12'h000, out_ready=1 -> after 2 cycles out_valid=1, first_vld=0, first_idx=4'hF, second_vld=0, second_idx=4'hF.
- Extremes and adjacency:
  - in_data=12'h801 -> first_idx=11, second_idx=0, both vld=1.
  - Then 12'h030 -> first_idx=5, second_idx=4.
  - Then 12'h400 -> first_idx=10, second_vld=0, second_idx=4'hF.
- Streaming: 8 back-to-back vectors with out_ready=1 -> in_ready stays 1, results appear in order, one per cycle, starting 2 cycles after the first.
- Backpressure: hold out_ready=0 while offering 3 vectors (12'h003, 12'h00C, 12'h030):
  - Exactly 2 are accepted, then in_ready=0.
  - Outputs hold first_idx=1 / second_idx=0.
  - Raising out_ready drains 1/0, 3/2, 5/4 in order with no loss.
- LSB-first build (MSB_FIRST=0):
  - in_data=12'h801 -> first_idx=0, second_idx=11.
  - in_data=12'h0A0 -> first_idx=5, second_idx=7.
- Reset mid-flight: assert reset asynchronously with both stages full -> out_valid drops the same instant, idx fields go to 4'hF, in_ready=1 after deassert, and no stale result appears afterwards.
